// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left or parallel load, with a
// shift counter that pulses word_valid once every WIDTH shifts.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             pi,
  input  logic                         sin_r,
  input  logic                         sin_l,
  output logic [WIDTH-1:0]             po,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic [$clog2(WIDTH)-1:0]     cnt,
  output logic                         word_valid
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeShr  = 2'b01,
    ModeShl  = 2'b10,
    ModeLoad = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_po;
  logic [CntW-1:0]  r_cnt;
  logic             r_word_valid;

  logic [WIDTH-1:0] w_po_d;
  logic [CntW-1:0]  w_cnt_d;
  logic             w_word_valid_d;
  logic             w_shift;

  always_comb begin
    w_po_d         = r_po;
    w_cnt_d        = r_cnt;
    w_word_valid_d = 1'b0;
    w_shift        = 1'b0;
    if (clr) begin
      w_po_d  = '0;
      w_cnt_d = '0;
    end else if (en) begin
      unique case (mode_e'(mode))
        ModeHold: ;
        ModeShr: begin
          w_po_d  = {sin_r, r_po[WIDTH-1:1]};
          w_shift = 1'b1;
        end
        ModeShl: begin
          w_po_d  = {r_po[WIDTH-2:0], sin_l};
          w_shift = 1'b1;
        end
        ModeLoad: begin
          w_po_d  = pi;
          w_cnt_d = '0;
        end
      endcase
    end
    // Both directions share one counter; the last shift of a word wraps it.
    if (w_shift) begin
      if (r_cnt == CntLast) begin
        w_cnt_d        = '0;
        w_word_valid_d = 1'b1;
      end else begin
        w_cnt_d = r_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_po         <= '0;
      r_cnt        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_po         <= w_po_d;
      r_cnt        <= w_cnt_d;
      r_word_valid <= w_word_valid_d;
    end
  end

  assign po         = r_po;
  assign cnt        = r_cnt;
  assign word_valid = r_word_valid;
  assign sout_r     = r_po[0];
  assign sout_l     = r_po[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         clr;
  logic [1:0]   mode;
  logic [W-1:0] pi;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] po;
  logic         sout_r;
  logic         sout_l;
  logic [2:0]   cnt;
  logic         word_valid;

  int n_vec  = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .mode       (mode),
    .pi         (pi),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .po         (po),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .cnt        (cnt),
    .word_valid (word_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks po, cnt and word_valid together.
  task automatic chk_state(input string tag, input logic [7:0] e_po, input logic [2:0] e_cnt,
                           input logic e_wv);
    chk({tag, ".po"}, 64'(po), 64'(e_po));
    chk({tag, ".cnt"}, 64'(cnt), 64'(e_cnt));
    chk({tag, ".wv"}, 64'(word_valid), 64'(e_wv));
  endtask

  int    wv_seen;
  bit    sin_bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  bit    piso_exp [8] = '{1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    mode  = 2'b11;
    pi    = 8'hFF;
    sin_r = 1'b1;
    sin_l = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_state("reset", 8'h00, 3'd0, 1'b0);
    chk("reset.sout_r", 64'(sout_r), 64'd0);
    chk("reset.sout_l", 64'(sout_l), 64'd0);
    // Inputs request a load of FF across two edges while reset is held.
    tick();
    tick();
    chk_state("reset_ignore", 8'h00, 3'd0, 1'b0);
    rst = 1'b1;

    // Load A5
    pi = 8'hA5;
    tick();
    chk_state("load_a5", 8'hA5, 3'd0, 1'b0);
    chk("load_a5.sout_r", 64'(sout_r), 64'd1);
    chk("load_a5.sout_l", 64'(sout_l), 64'd1);

    // Hold with en=1, mode=00
    mode = 2'b00;
    tick();
    chk_state("hold", 8'hA5, 3'd0, 1'b0);

    // SIPO: 1,0,1,1,0,0,1,0 shifted right -> 4D
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      sin_r = sin_bits[i];
      tick();
      if (i < 7) chk_state($sformatf("sipo%0d", i), po, 3'(i + 1), 1'b0);
    end
    chk_state("sipo_done", 8'h4D, 3'd0, 1'b1);
    mode = 2'b00;
    tick();
    chk_state("sipo_after", 8'h4D, 3'd0, 1'b0);

    // PISO: load 81, shift left with sin_l=0
    mode = 2'b11;
    pi   = 8'h81;
    tick();
    mode    = 2'b10;
    sin_l   = 1'b0;
    wv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("piso_sout_l%0d", i), 64'(sout_l), 64'(piso_exp[i]));
      tick();
      if (word_valid) wv_seen++;
    end
    chk_state("piso_done", 8'h00, 3'd0, 1'b1);
    mode = 2'b00;
    tick();
    if (word_valid) wv_seen++;
    chk("piso_pulses", 64'(wv_seen), 64'd1);

    // Gating: load 3C, en=0 for 3 cycles, then clr with en=0
    mode = 2'b11;
    pi   = 8'h3C;
    tick();
    chk("gate.sout_r", 64'(sout_r), 64'd0);
    en   = 1'b0;
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state($sformatf("gate%0d", i), 8'h3C, 3'd0, 1'b0);
    end
    clr = 1'b1;
    tick();
    chk_state("gate_clr", 8'h00, 3'd0, 1'b0);

    // clr beats an enabled load and clears a partial count
    clr   = 1'b0;
    en    = 1'b1;
    sin_r = 1'b1;
    tick();
    tick();
    chk_state("pre_clr", 8'hC0, 3'd2, 1'b0);
    clr  = 1'b1;
    mode = 2'b11;
    pi   = 8'hFF;
    tick();
    chk_state("clr_prio", 8'h00, 3'd0, 1'b0);
    clr = 1'b0;

    // Async reset mid-word after 5 shifts
    mode  = 2'b01;
    sin_r = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_state("pre_rst", 8'hF8, 3'd5, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_state("async_rst", 8'h00, 3'd0, 1'b0);
    #1 rst = 1'b1;
    sin_r   = 1'b0;
    wv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (word_valid) wv_seen++;
      if (i == 6) chk("rst_no_early_wv", 64'(word_valid), 64'd0);
    end
    chk_state("rst_word", 8'h00, 3'd0, 1'b1);
    chk("rst_pulses", 64'(wv_seen), 64'd1);

    // Mixed: 4 right (sin_r=1) then 4 left (sin_l=1), back-to-back with previous word
    sin_r = 1'b1;
    sin_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode = (i < 4) ? 2'b01 : 2'b10;
      tick();
      if (i == 3) chk_state("mixed_mid", 8'hF0, 3'd4, 1'b0);
      if (i == 6) chk("mixed_no_wv7", 64'(word_valid), 64'd0);
    end
    chk_state("mixed_done", 8'h0F, 3'd0, 1'b1);

    // Same word pattern with a hold inserted at shift 6: pulse one cycle later
    wv_seen = 0;
    for (int i = 0; i < 9; i++) begin
      mode = (i == 5) ? 2'b00 : ((i < 4) ? 2'b01 : 2'b10);
      tick();
      if (word_valid) wv_seen++;
      if (i == 5) chk_state("held_at6", po, 3'd5, 1'b0);
      if (i == 7) chk("held_no_wv8", 64'(word_valid), 64'd0);
    end
    chk("held_wv9", 64'(word_valid), 64'd1);
    chk("held_pulses", 64'(wv_seen), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
